// File: rtl/decode_queue.sv
// Instruction decode queue: a small circular buffer of fetched {inst, pc} entries whose head is
// decoded combinationally into RV32I type code, register fields and sign-extended immediate.
module decode_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned INST_TYPE_WIDTH = 6
) (
   input  logic                       clk_in,
   input  logic                       rst_n,
   input  logic                       flush_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_inst,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_TYPE_WIDTH-1:0] order_type,
   output logic [4:0]                 order_rd,
   output logic [4:0]                 order_rs1,
   output logic [4:0]                 order_rs2,
   output logic [31:0]                order_imm,
   output logic [PC_WIDTH-1:0]        order_pc,
   output logic                       illegal
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Codebase type codes: 0 is reserved for illegal, then LUI..AND in RV32I listing order.
   typedef enum logic [5:0] {
      TyIllegal, TyLui, TyAuipc, TyJal, TyJalr,
      TyBeq, TyBne, TyBlt, TyBge, TyBltu, TyBgeu,
      TyLb, TyLh, TyLw, TyLbu, TyLhu,
      TySb, TySh, TySw,
      TyAddi, TySlti, TySltiu, TyXori, TyOri, TyAndi, TySlli, TySrli, TySrai,
      TyAdd, TySub, TySll, TySlt, TySltu, TyXor, TySrl, TySra, TyOr, TyAnd
   } inst_type_e;

   logic [31:0]         inst_mem [DEPTH];
   logic [PC_WIDTH-1:0] pc_mem   [DEPTH];

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push, pop;

   assign in_ready  = (count_q < FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Storage is intentionally not reset; count gates every use of it.
   always_ff @(posedge clk_in) begin
      if (push && !flush_in) begin
         inst_mem[wr_ptr_q] <= in_inst;
         pc_mem[wr_ptr_q]   <= in_pc;
      end
   end

   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign inst   = inst_mem[rd_ptr_q];
   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_sh = {27'b0, inst[24:20]};

   inst_type_e  dec_type;
   logic [31:0] dec_imm;

   always_comb begin
      dec_type = TyIllegal;
      dec_imm  = '0;
      case (opcode)
         7'h37: begin dec_type = TyLui;   dec_imm = imm_u; end
         7'h17: begin dec_type = TyAuipc; dec_imm = imm_u; end
         7'h6f: begin dec_type = TyJal;   dec_imm = imm_j; end
         7'h67: begin
            if (f3 == 3'd0) dec_type = TyJalr;
            dec_imm = imm_i;
         end
         7'h03: begin
            case (f3)
               3'd0:    dec_type = TyLb;
               3'd1:    dec_type = TyLh;
               3'd2:    dec_type = TyLw;
               3'd4:    dec_type = TyLbu;
               3'd5:    dec_type = TyLhu;
               default: dec_type = TyIllegal;
            endcase
            dec_imm = imm_i;
         end
         7'h23: begin
            case (f3)
               3'd0:    dec_type = TySb;
               3'd1:    dec_type = TySh;
               3'd2:    dec_type = TySw;
               default: dec_type = TyIllegal;
            endcase
            dec_imm = imm_s;
         end
         7'h63: begin
            case (f3)
               3'd0:    dec_type = TyBeq;
               3'd1:    dec_type = TyBne;
               3'd4:    dec_type = TyBlt;
               3'd5:    dec_type = TyBge;
               3'd6:    dec_type = TyBltu;
               3'd7:    dec_type = TyBgeu;
               default: dec_type = TyIllegal;
            endcase
            dec_imm = imm_b;
         end
         7'h13: begin
            dec_imm = imm_i;
            case (f3)
               3'd0: dec_type = TyAddi;
               3'd2: dec_type = TySlti;
               3'd3: dec_type = TySltiu;
               3'd4: dec_type = TyXori;
               3'd6: dec_type = TyOri;
               3'd7: dec_type = TyAndi;
               3'd1: begin
                  if (f7 == 7'h00) dec_type = TySlli;
                  dec_imm = imm_sh;
               end
               default: begin
                  if (f7 == 7'h00)      dec_type = TySrli;
                  else if (f7 == 7'h20) dec_type = TySrai;
                  dec_imm = imm_sh;
               end
            endcase
         end
         7'h33: begin
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0:    dec_type = TyAdd;
                  3'd1:    dec_type = TySll;
                  3'd2:    dec_type = TySlt;
                  3'd3:    dec_type = TySltu;
                  3'd4:    dec_type = TyXor;
                  3'd5:    dec_type = TySrl;
                  3'd6:    dec_type = TyOr;
                  default: dec_type = TyAnd;
               endcase
            end else if (f7 == 7'h20) begin
               if (f3 == 3'd0)      dec_type = TySub;
               else if (f3 == 3'd5) dec_type = TySra;
            end
         end
         default: dec_type = TyIllegal;
      endcase
      if (dec_type == TyIllegal) dec_imm = '0;
   end

   assign order_type = INST_TYPE_WIDTH'(dec_type);
   assign order_rd   = inst[11:7];
   assign order_rs1  = inst[19:15];
   assign order_rs2  = inst[24:20];
   assign order_imm  = dec_imm;
   assign order_pc   = pc_mem[rd_ptr_q];
   assign illegal    = out_valid && (dec_type == TyIllegal);

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, >=2.
REQ-002 Parameter PC_WIDTH, default 32, width of carried PC.
REQ-003 clk_in  input  1  sole clock; all state SHALL change on its rising edge, except reset.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush_in  input  1  discard all queued entries (branch mispredict/exception).
REQ-006 in_valid  input  1  fetch offers an instruction.
REQ-007 in_ready  output  1  queue can accept; SHALL equal (count < DEPTH).
REQ-008 in_inst  input  32  raw RV32I instruction word.
REQ-009 in_pc  input  PC_WIDTH  PC of in_inst.
REQ-010 out_valid  output  1  head entry decoded and presented; SHALL equal (count != 0).
REQ-011 out_ready  input  1  consumer takes head this cycle.
REQ-012 order_type  output  INST_TYPE_WIDTH  codebase instruction-type code of head (LUI..AND); 0 when illegal.
REQ-013 order_rd, order_rs1, order_rs2  output  5 each  register fields inst[11:7], [19:15], [24:20].
REQ-014 order_imm  output  32  fully sign-extended immediate.
REQ-015 order_pc  output  PC_WIDTH  PC of head.
REQ-016 illegal  output  1  head is not a valid RV32I instruction.

Function
REQ-017 Storage: circular buffer of DEPTH {inst, pc} entries, read/write pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, count of log2(DEPTH)+1 bits.
REQ-018 Push when in_valid && in_ready; pop when out_valid && out_ready; both may occur in one cycle, count unchanged.
REQ-019 in_ready SHALL depend only on count: when full, no push even if a pop occurs that cycle.
REQ-020 Latency: entry pushed at edge N SHALL appear on outputs after edge N if queue was empty; FIFO order preserved.
REQ-021 Outputs SHALL be combinational decode of the head entry; with out_valid=0 they are don't-care except illegal=0.
REQ-022 flush_in SHALL have priority: pointers and count return to 0; same-cycle push and pop are ignored.
REQ-023 Decode: U (0x37 LUI, 0x17 AUIPC) imm={inst[31:12],12'b0}.
REQ-024 I-type (0x67 JALR, 0x03 loads, 0x13 ALU-imm) imm=sext(inst[31:20]); SLLI/SRLI/SRAI imm=zext(inst[24:20]).
REQ-025 S (0x23) imm=sext({inst[31:25],inst[11:7]}); B (0x63) imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); J (0x6f) imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
REQ-026 R (0x33) types by funct3/funct7 as RV32I; funct7 other than 0x00 (or 0x20 for ADD/SUB, SRL/SRA) SHALL be illegal.
REQ-027 illegal=1 for: unknown opcode; load funct3 3,6,7; store funct3 >2; branch funct3 2,3; JALR funct3 !=0; SLLI funct7 !=0; SRLI/SRAI funct7 not 0x00/0x20; inst[1:0]!=2'b11.
REQ-028 Illegal entries SHALL still be queued and popped normally; order_type=0.

Reset
REQ-029 While rst_n=0: count, pointers = 0; out_valid=0, in_ready=1, illegal=0; storage contents not reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk_in.
REQ-031 First push SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-032 Reset release -> out_valid=0, in_ready=1, illegal=0.
REQ-033 Push 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> next cycle out_valid=1, order_type=ADDI, rd=1, rs1=0, imm=0xFFFFFFFF, order_pc=0x100.
REQ-034 DEPTH=4: push 5 words, out_ready=0 -> in_ready=0 after 4th, 5th dropped; then pop 4 -> words 1-4 in order, pointers wrap, out_valid=0.
REQ-035 Push 0xFE000EE3 (beq x0,x0,-4) -> BEQ, imm=0xFFFFFFFC; push 0x4051D113 (srai x2,x3,5) -> SRAI, rd=2, rs1=3, imm=5.
REQ-036 Push 0x00000000 -> illegal=1, order_type=0; pop clears it.
REQ-037 Queue holding 3, flush_in=1 with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, pushed word absent.
